// File: rtl/m_dmem_stage_if.sv
// rtl/m_dmem_stage_if.sv - E/M stage inputs and M/W stage outputs of the data-memory stage
//
// Purpose: bundles the M-stage operands presented to the data-memory stage and
// the registered W-stage results it returns.
// Signals:
//   M_instr, M_ALUresult, M_rt, M_pc  : M-stage instruction, address/pass-through, store data, PC
//   dm_busy                           : memory clear sweep in progress (pipeline freeze)
//   W_instr, W_ALUresult, W_memdata,
//   W_pc, W_fault                     : registered results for the W stage
// Modports: master = pipeline side (drives M_*), slave = memory stage (drives W_*, dm_busy).
interface m_dmem_stage_if;
  logic [31:0] M_instr;
  logic [31:0] M_ALUresult;
  logic [31:0] M_rt;
  logic [31:0] M_pc;
  logic        dm_busy;
  logic [31:0] W_instr;
  logic [31:0] W_ALUresult;
  logic [31:0] W_memdata;
  logic [31:0] W_pc;
  logic        W_fault;

  modport master (
    output M_instr, M_ALUresult, M_rt, M_pc,
    input  dm_busy, W_instr, W_ALUresult, W_memdata, W_pc, W_fault
  );

  modport slave (
    input  M_instr, M_ALUresult, M_rt, M_pc,
    output dm_busy, W_instr, W_ALUresult, W_memdata, W_pc, W_fault
  );
endinterface

// File: rtl/m_dmem_stage.sv
// rtl/m_dmem_stage.sv - MIPS memory stage: word-organised data memory with clear sweep and M/W register
//
// Purpose: decodes loads/stores from the M-stage instruction, performs byte/half/word
// stores into a 2^ADDR_WIDTH x 32 memory, extends load data, and registers the results
// into the M/W boundary. After reset the whole memory is swept to zero while dm_busy
// holds the pipeline frozen.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : m_dmem_stage_if slave (M_* inputs, W_* and dm_busy outputs)
module m_dmem_stage #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic           clk,
  input  logic           reset,
  m_dmem_stage_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Terminal sweep value; the pointer carries one spare bit so this compare never wraps.
  localparam logic [ADDR_WIDTH:0] LAST_WORD = {1'b0, {ADDR_WIDTH{1'b1}}};

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH:0]   r_clr_ptr;
  logic [ADDR_WIDTH:0]   w_clr_ptr_nxt;

  logic [31:0]           r_mem [0:DEPTH-1];

  logic [31:0]           r_w_instr;
  logic [31:0]           r_w_aluresult;
  logic [31:0]           r_w_memdata;
  logic [31:0]           r_w_pc;
  logic                  r_w_fault;

  logic [31:0]           w_addr;
  logic [ADDR_WIDTH-1:0] w_word_idx;
  logic                  w_is_load;
  logic                  w_is_store;
  logic                  w_signed;
  logic [1:0]            w_size;
  logic                  w_oor;
  logic                  w_misal;
  logic                  w_fault;

  logic [3:0]            w_we;
  logic [ADDR_WIDTH-1:0] w_widx;
  logic [31:0]           w_wdata;

  logic [31:0]           w_rword;
  logic [7:0]            w_rbyte;
  logic [15:0]           w_rhalf;
  logic [31:0]           w_ld_data;
  logic [31:0]           w_memdata_nxt;

  assign w_addr     = bus.M_ALUresult;
  assign w_word_idx = w_addr[ADDR_WIDTH+1:2];

  // Opcode decode
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_signed   = 1'b0;
    w_size     = SZ_WORD;
    case (bus.M_instr[31:26])
      OP_LW:  begin w_is_load  = 1'b1; w_size = SZ_WORD; end
      OP_LH:  begin w_is_load  = 1'b1; w_size = SZ_HALF; w_signed = 1'b1; end
      OP_LHU: begin w_is_load  = 1'b1; w_size = SZ_HALF; end
      OP_LB:  begin w_is_load  = 1'b1; w_size = SZ_BYTE; w_signed = 1'b1; end
      OP_LBU: begin w_is_load  = 1'b1; w_size = SZ_BYTE; end
      OP_SW:  begin w_is_store = 1'b1; w_size = SZ_WORD; end
      OP_SH:  begin w_is_store = 1'b1; w_size = SZ_HALF; end
      OP_SB:  begin w_is_store = 1'b1; w_size = SZ_BYTE; end
      default: ;
    endcase
  end

  assign w_oor   = |w_addr[31:ADDR_WIDTH+2];
  assign w_misal = ((w_size == SZ_WORD) && (w_addr[1:0] != 2'b00)) ||
                   ((w_size == SZ_HALF) && w_addr[0]);
  assign w_fault = (w_is_load || w_is_store) && (w_oor || w_misal);

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    case (r_state)
      CLEAR: begin
        w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        if (r_clr_ptr == LAST_WORD) begin
          w_state_nxt = RUN;
        end
      end
      RUN: ;
      default: w_state_nxt = CLEAR;
    endcase
  end

  // Single write port shared by the clear sweep and pipeline stores; the two
  // never coincide because stores are ignored while clearing.
  always_comb begin
    w_we    = 4'b0000;
    w_widx  = w_word_idx;
    w_wdata = 32'h0;
    if (r_state == CLEAR) begin
      w_we   = 4'b1111;
      w_widx = r_clr_ptr[ADDR_WIDTH-1:0];
    end else if (w_is_store && !w_fault) begin
      case (w_size)
        SZ_WORD: begin
          w_we    = 4'b1111;
          w_wdata = bus.M_rt;
        end
        SZ_HALF: begin
          w_we    = w_addr[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{bus.M_rt[15:0]}};
        end
        default: begin
          w_we    = 4'b0001 << w_addr[1:0];
          w_wdata = {4{bus.M_rt[7:0]}};
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (w_we[l]) begin
        r_mem[w_widx][l*8 +: 8] <= w_wdata[l*8 +: 8];
      end
    end
  end

  // Combinational read and lane extraction
  assign w_rword = r_mem[w_word_idx];
  assign w_rbyte = w_rword[{w_addr[1:0], 3'b000} +: 8];
  assign w_rhalf = w_addr[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_ld_data = w_rword;
    case (w_size)
      SZ_BYTE: w_ld_data = w_signed ? {{24{w_rbyte[7]}}, w_rbyte} : {24'h0, w_rbyte};
      SZ_HALF: w_ld_data = w_signed ? {{16{w_rhalf[15]}}, w_rhalf} : {16'h0, w_rhalf};
      default: w_ld_data = w_rword;
    endcase
  end

  assign w_memdata_nxt = (w_is_load && !w_fault) ? w_ld_data : 32'h0;

  // M/W boundary register; bubbles (all zero) while the sweep runs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_w_instr     <= 32'h0;
      r_w_aluresult <= 32'h0;
      r_w_memdata   <= 32'h0;
      r_w_pc        <= 32'h0;
      r_w_fault     <= 1'b0;
    end else if (r_state == CLEAR) begin
      r_w_instr     <= 32'h0;
      r_w_aluresult <= 32'h0;
      r_w_memdata   <= 32'h0;
      r_w_pc        <= 32'h0;
      r_w_fault     <= 1'b0;
    end else begin
      r_w_instr     <= bus.M_instr;
      r_w_aluresult <= bus.M_ALUresult;
      r_w_memdata   <= w_memdata_nxt;
      r_w_pc        <= bus.M_pc;
      r_w_fault     <= w_fault;
    end
  end

  assign bus.dm_busy     = (r_state == CLEAR);
  assign bus.W_instr     = r_w_instr;
  assign bus.W_ALUresult = r_w_aluresult;
  assign bus.W_memdata   = r_w_memdata;
  assign bus.W_pc        = r_w_pc;
  assign bus.W_fault     = r_w_fault;

endmodule

// File: tb/tb_m_dmem_stage.sv
// tb/tb_m_dmem_stage.sv - directed self-checking bench for m_dmem_stage
module tb_m_dmem_stage;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  m_dmem_stage_if bus ();

  m_dmem_stage #(.ADDR_WIDTH(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_LW   = 32'h8C000001;
  localparam logic [31:0] I_LH   = 32'h84000002;
  localparam logic [31:0] I_LHU  = 32'h94000003;
  localparam logic [31:0] I_LB   = 32'h80000004;
  localparam logic [31:0] I_LBU  = 32'h90000005;
  localparam logic [31:0] I_SW   = 32'hAC000006;
  localparam logic [31:0] I_SH   = 32'hA4000007;
  localparam logic [31:0] I_SB   = 32'hA0000008;
  localparam logic [31:0] I_ADDU = 32'h00851021;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] alu,
                       input logic [31:0] rt, input logic [31:0] pc);
    bus.M_instr     = instr;
    bus.M_ALUresult = alu;
    bus.M_rt        = rt;
    bus.M_pc        = pc;
  endtask

  task automatic step(input logic [31:0] instr, input logic [31:0] alu,
                      input logic [31:0] rt, input logic [31:0] pc);
    drive(instr, alu, rt, pc);
    @(posedge clk);
    #1;
  endtask

  // Counts edges until dm_busy drops; called just after reset release, mid-cycle.
  // While the sweep runs, the W stage must stay a bubble despite the driven inputs.
  task automatic sweep_check(input string tag);
    int n;
    logic w_nonzero;
    n = 0;
    w_nonzero = 1'b0;
    while (bus.dm_busy === 1'b1 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.dm_busy === 1'b1 && (bus.W_instr !== 32'h0 || bus.W_fault !== 1'b0))
        w_nonzero = 1'b1;
    end
    drive(32'h0, 32'h0, 32'h0, 32'h0);
    chk({tag, "_len"}, n, 32'd4096);
    chk({tag, "_bubble"}, {31'h0, w_nonzero}, 32'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(32'h0, 32'h0, 32'h0, 32'h0);

    // Reset state
    reset = 1'b0;
    #1;
    chk("rst_busy",    {31'h0, bus.dm_busy}, 32'h1);
    chk("rst_instr",   bus.W_instr,   32'h0);
    chk("rst_memdata", bus.W_memdata, 32'h0);
    chk("rst_fault",   {31'h0, bus.W_fault}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sweep_check("sweep0");

    // Preload mem[5]
    step(I_SW, 32'h14, 32'hDEADBEEF, 32'h100);
    step(I_LW, 32'h14, 32'h0, 32'h104);
    chk("pre_lw", bus.W_memdata, 32'hDEADBEEF);

    // Word store/load
    step(I_SW, 32'h100, 32'h12345678, 32'h108);
    chk("sw_fault", {31'h0, bus.W_fault}, 32'h0);
    chk("sw_memdata", bus.W_memdata, 32'h0);
    step(I_LW, 32'h100, 32'h0, 32'h400);
    chk("lw_data",  bus.W_memdata, 32'h12345678);
    chk("lw_fault", {31'h0, bus.W_fault}, 32'h0);
    chk("lw_pc",    bus.W_pc, 32'h400);
    chk("lw_instr", bus.W_instr, I_LW);

    // Byte lanes
    step(I_SB, 32'h101, 32'h000000AB, 32'h404);
    step(I_LW, 32'h100, 32'h0, 32'h408);
    chk("sb_word", bus.W_memdata, 32'h1234AB78);
    step(I_LB, 32'h101, 32'h0, 32'h40C);
    chk("lb", bus.W_memdata, 32'hFFFFFFAB);
    step(I_LBU, 32'h101, 32'h0, 32'h410);
    chk("lbu", bus.W_memdata, 32'h000000AB);

    // Halfword lanes
    step(I_SH, 32'h102, 32'h00008001, 32'h414);
    step(I_LH, 32'h102, 32'h0, 32'h418);
    chk("lh", bus.W_memdata, 32'hFFFF8001);
    step(I_LHU, 32'h102, 32'h0, 32'h41C);
    chk("lhu", bus.W_memdata, 32'h00008001);
    step(I_LW, 32'h100, 32'h0, 32'h420);
    chk("sh_word", bus.W_memdata, 32'h8001AB78);

    // Faults
    step(I_SW, 32'h102, 32'hFFFFFFFF, 32'h424);
    chk("sw_mis_fault", {31'h0, bus.W_fault}, 32'h1);
    step(I_LW, 32'h100, 32'h0, 32'h428);
    chk("sw_mis_nowrite", bus.W_memdata, 32'h8001AB78);
    chk("lw_ok_fault", {31'h0, bus.W_fault}, 32'h0);
    step(I_LH, 32'h103, 32'h0, 32'h42C);
    chk("lh_mis_data",  bus.W_memdata, 32'h0);
    chk("lh_mis_fault", {31'h0, bus.W_fault}, 32'h1);
    step(I_LW, 32'h00010000, 32'h0, 32'h430);
    chk("lw_oor_data",  bus.W_memdata, 32'h0);
    chk("lw_oor_fault", {31'h0, bus.W_fault}, 32'h1);
    step(I_LW, 32'h00010100, 32'h0, 32'h434);
    chk("lw_oor_alias", bus.W_memdata, 32'h0);
    step(I_SW, 32'h00010100, 32'h11111111, 32'h438);
    chk("sw_oor_fault", {31'h0, bus.W_fault}, 32'h1);
    step(I_LW, 32'h100, 32'h0, 32'h43C);
    chk("sw_oor_nowrite", bus.W_memdata, 32'h8001AB78);

    // Non-memory pass-through
    step(I_ADDU, 32'h00000042, 32'h8001AB78, 32'h440);
    chk("addu_alu",   bus.W_ALUresult, 32'h42);
    chk("addu_mem",   bus.W_memdata, 32'h0);
    chk("addu_fault", {31'h0, bus.W_fault}, 32'h0);
    chk("addu_instr", bus.W_instr, I_ADDU);
    step(I_LW, 32'h100, 32'h0, 32'h444);
    chk("addu_untouched", bus.W_memdata, 32'h8001AB78);

    // Reset pulse from RUN: W clears asynchronously, sweep zeroes memory
    reset = 1'b0;
    #1;
    chk("arst_memdata", bus.W_memdata, 32'h0);
    chk("arst_instr",   bus.W_instr, 32'h0);
    chk("arst_pc",      bus.W_pc, 32'h0);
    chk("arst_busy",    {31'h0, bus.dm_busy}, 32'h1);
    #2;
    reset = 1'b1;
    sweep_check("sweep1");
    step(I_LW, 32'h14, 32'h0, 32'h500);
    chk("clr_mem5", bus.W_memdata, 32'h0);
    step(I_LW, 32'h100, 32'h0, 32'h504);
    chk("clr_mem64", bus.W_memdata, 32'h0);

    // Reset mid-sweep with M inputs driven throughout
    step(I_SW, 32'h200, 32'hCAFEF00D, 32'h508);
    reset = 1'b0;
    #1;
    chk("mid_arst_instr", bus.W_instr, 32'h0);
    #2;
    reset = 1'b1;
    drive(I_SW, 32'h100, 32'h55555555, 32'h600);
    repeat (100) begin
      @(posedge clk);
      #1;
    end
    chk("mid_busy", {31'h0, bus.dm_busy}, 32'h1);
    chk("mid_instr", bus.W_instr, 32'h0);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", {31'h0, bus.dm_busy}, 32'h1);
    #2;
    reset = 1'b1;
    drive(I_SW, 32'h3FFC, 32'h55555555, 32'h600);
    begin
      int n;
      n = 0;
      while (bus.dm_busy === 1'b1 && n < 5000) begin
        @(posedge clk);
        #1;
        n++;
      end
      drive(32'h0, 32'h0, 32'h0, 32'h0);
      chk("mid_sweep_len", n, 32'd4096);
    end
    chk("mid_run_instr", bus.W_instr, 32'h0);
    step(I_LW, 32'h200, 32'h0, 32'h700);
    chk("mid_mem_200", bus.W_memdata, 32'h0);
    step(I_LW, 32'h3FFC, 32'h0, 32'h704);
    chk("mid_mem_last", bus.W_memdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_dmem_stage.md
Name: m_dmem_stage

Overview:
- Memory-stage consumer of the E/M pipeline register outputs (M_instr, M_ALUresult, M_rt, M_pc) in the 5-stage MIPS core.
- Holds the word-organised data memory. Decodes load/store from M_instr, performs byte/halfword/word stores, and sign- or zero-extends loads.
- Registers the results into the M/W boundary for the W stage.
- After reset it sweeps the whole memory to zero and holds the pipeline stalled until the sweep completes.

Parameters:
- ADDR_WIDTH, 12, word-address width; memory holds 2^ADDR_WIDTH 32-bit words (byte range 0 .. 4*2^ADDR_WIDTH-1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- M_instr  input  32  instruction in M stage.
- M_ALUresult  input  32  byte address for loads/stores; pass-through value for non-memory instructions.
- M_rt  input  32  store data.
- M_pc  input  32  PC of the M-stage instruction.
- dm_busy  output  1  1 while the clear sweep runs; the pipeline controller freezes F/D/E/M on it.
- W_instr  output  32  registered M_instr.
- W_ALUresult  output  32  registered M_ALUresult.
- W_memdata  output  32  registered, extended load data.
- W_pc  output  32  registered M_pc.
- W_fault  output  1  registered: the M-stage memory access was misaligned or out of range.

Behaviour:
- Opcode decode uses M_instr[31:26]:
  - lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100.
  - sw 101011, sh 101001, sb 101000.
  - All other opcodes are non-memory.
- Address: A = M_ALUresult; word index = A[ADDR_WIDTH+1:2].
- Out of range: A[31:ADDR_WIDTH+2] != 0.
- Misaligned: word access with A[1:0] != 0, or halfword access with A[0] != 0.
- Faulting store (misaligned or out of range): no memory write; W_fault=1 at the next edge.
- Faulting load: W_memdata=0 and W_fault=1.
- Stores are synchronous, written at the rising edge:
  - sw writes the whole word.
  - sh writes M_rt[15:0] to halfword A[1].
  - sb writes M_rt[7:0] to byte lane A[1:0].
  - All other lanes are unchanged.
- Loads read the array combinationally and are captured into W_memdata at the edge:
  - lb/lh sign-extend; lbu/lhu zero-extend; lane selected by A[1:0] / A[1].
- Non-memory instruction: W_memdata=0, W_fault=0.
- Latency: one cycle from M inputs to W outputs. A store at edge n is visible to a load presented in cycle n+1.
- FSM has two states, CLEAR and RUN.
  - reset=0 (asynchronous): state=CLEAR, clr_ptr=0, all W_* outputs = 0, dm_busy=1.
  - CLEAR, after reset is released: each edge writes 32'h0 to mem[clr_ptr] and increments clr_ptr.
    - When the edge writes word 2^ADDR_WIDTH-1, the next state is RUN.
    - The sweep takes exactly 2^ADDR_WIDTH edges.
    - M inputs are ignored and W_* are held 0 (bubble).
    - dm_busy=1 throughout CLEAR and goes 0 in the first RUN cycle.
  - RUN: normal operation, dm_busy=0, remains in RUN until reset.
- Reset asserted mid-sweep or mid-run: returns to CLEAR with clr_ptr=0. The sweep restarts from word 0; the previous progress is discarded.
- clr_ptr is ADDR_WIDTH+1 bits wide, so the terminal compare does not wrap.
- Only one M-stage instruction exists per cycle, so there are no simultaneous read/write port conflicts.
- The clear write and a pipeline store never coincide, because stores are ignored in CLEAR.

Test Plan:
- Reset sweep: pre-load mem[5]=32'hDEADBEEF via a store in RUN, pulse reset low, release. Required: dm_busy=1 for exactly 2^ADDR_WIDTH cycles, then 0. A following lw from 0x14 returns W_memdata=0.
- Word store/load: sw M_rt=32'h12345678 to A=0x100, next cycle lw A=0x100. Required: W_memdata=32'h12345678, W_fault=0, W_pc equals the lw M_pc.
- Byte/half lanes on word 0x12345678 at A=0x100:
  - sb 8'hAB to 0x101 -> word reads 32'h1234AB78.
  - lb 0x101 -> 32'hFFFFFFAB; lbu 0x101 -> 32'h000000AB.
  - sh 16'h8001 to 0x102, then lh 0x102 -> 32'hFFFF8001; lhu 0x102 -> 32'h00008001.
- Faults:
  - sw to 0x102 -> memory unchanged, W_fault=1.
  - lh from 0x103 -> W_memdata=0, W_fault=1.
  - lw from 32'h0001_0000 (ADDR_WIDTH=12) -> W_memdata=0, W_fault=1.
- Non-memory pass-through: addu with M_ALUresult=32'h00000042. Required: W_ALUresult=32'h42, W_memdata=0, W_fault=0, W_instr=M_instr, memory untouched.
- Reset mid-sweep: assert reset at clr_ptr=100, release. Required: W_* go 0 asynchronously, dm_busy stays 1 for a full 2^ADDR_WIDTH cycles after release, and M inputs are ignored during that time.
